mult6_rr_sched: RTL

- Shares one iterative 6x6 unsigned shift-and-add multiplier among NREQ requesters.
- Arbitrates between requesters round-robin and accepts one operand pair per job.
- Runs the multiply one multiplier bit per clock and returns the 12-bit product with the requester id on a valid/ready response port.
- Sits between requesting blocks and the shared arithmetic resource, replacing per-requester combinational multipliers.

---
 rtl/mult6_pkg.sv | 19 +
 rtl/mult6_rr_pick.sv | 33 +++
 rtl/mult6_rr_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mult6_pkg.sv
// Shared types and defaults for the round-robin 6x6 multiplier scheduler.
// The MULT6_EARLY_EXIT_EN build option is consumed by mult6_rr_sched.
package mult6_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Requester id width; never narrower than one bit.
  function automatic int unsigned idw_f(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult6_rr_pick.sv
// Combinational round-robin picker: first valid requester strictly after ptr,
// wrapping from NREQ-1 back to 0.
module mult6_rr_pick
  import mult6_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  grant_idx_c,
  output logic            any_c
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!any_c && req_valid[idx]) begin
        any_c        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

endmodule

// File: rtl/mult6_rr_sched.sv
// Shared iterative shift-and-add multiplier with round-robin request arbitration.
// Define MULT6_EARLY_EXIT_EN to end RUN as soon as the remaining multiplier bits are zero.
module mult6_rr_sched
  import mult6_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDW   = idw_f(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_axb,
  output logic                  busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   grant_c;
  logic [IDW-1:0]    grant_idx_c;
  logic              any_c;
  logic [WIDTH-1:0]  a_sel_c, b_sel_c;

  mult6_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid   (req_valid),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_c)
  );

  // One-hot operand select for the granted requester.
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        a_sel_c = req_a[i*WIDTH +: WIDTH];
        b_sel_c = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready = (state_q == IDLE) ? grant_c : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_c) begin
          a_d     = a_sel_c;
          b_d     = b_sel_c;
          id_d    = grant_idx_c;
          ptr_d   = grant_idx_c;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MULT6_EARLY_EXIT_EN
        if (b_q[0]) prod_d = prod_q + (PW'(a_q) << cnt_q);
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (b_d == '0) state_d = DONE;
`else
        if (b_q[cnt_q]) prod_d = prod_q + (PW'(a_q) << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
`endif
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_axb   = prod_q;
  assign busy      = busy_q;

endmodule
